// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.

module alu #(
    parameter int BW = 16
) (
    input  logic [2:0]    op,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    output logic [BW-1:0] out,
    output logic [2:0]    flags
);

    logic [BW-1:0] res;
    logic          ovf;

    // Overflow is signed overflow for the arithmetic ops; logic/move ops never overflow.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            3'd0: begin
                res = a + b;
                ovf = (a[BW-1] == b[BW-1]) && (res[BW-1] != a[BW-1]);
            end
            3'd1: begin
                res = a - b;
                ovf = (a[BW-1] != b[BW-1]) && (res[BW-1] != a[BW-1]);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin
                res = a + BW'(1);
                ovf = !a[BW-1] && res[BW-1];
            end
            3'd6: res = a;
            3'd7: res = b;
        endcase
        out   = res;
        flags = {ovf, res[BW-1], (res == '0)};
    end

endmodule

module alu_arbiter #(
    parameter int BW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [3:0]    req0_opcode,
    input  logic [BW-1:0] req0_a,
    input  logic [BW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [3:0]    req1_opcode,
    input  logic [BW-1:0] req1_a,
    input  logic [BW-1:0] req1_b,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [BW-1:0] rsp_out,
    output logic [2:0]    rsp_flags,
    output logic          rsp_err,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, next_state;
    logic          pick, accept, rsp_hs, grant_q;
    logic [3:0]    op_q;
    logic [BW-1:0] a_q, b_q, alu_out;
    logic [2:0]    alu_flags;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic          last_grant;
`endif

    // Grant choice: a lone requester always wins; contention goes to the other port
    // than last time, or to port 0 in the fixed-priority build.
    always_comb begin
        pick = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            pick = 1'b0;
`else
            pick = ~last_grant;
`endif
        end else if (req1_valid) begin
            pick = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = rst_n && accept && !pick;
    assign req1_ready = rst_n && accept && pick;
    assign rsp0_valid = (state == RESP) && !grant_q;
    assign rsp1_valid = (state == RESP) && grant_q;
    assign rsp_hs     = (state == RESP) && (grant_q ? rsp1_ready : rsp0_ready);
    assign busy       = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_hs) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                grant_q <= pick;
                op_q    <= pick ? req1_opcode : req0_opcode;
                a_q     <= pick ? req1_a : req0_a;
                b_q     <= pick ? req1_b : req0_b;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Reset to 1 so that port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= pick;
        end
    end
`endif

    // The ALU sees only the captured operands, never a live request port.
    alu #(.BW(BW)) u_alu (
        .op    (op_q[2:0]),
        .a     (a_q),
        .b     (b_q),
        .out   (alu_out),
        .flags (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_out   <= '0;
            rsp_flags <= 3'b000;
            rsp_err   <= 1'b0;
        end else if (state == EXEC) begin
            if (op_q[3]) begin
                rsp_out   <= '0;
                rsp_flags <= 3'b000;
                rsp_err   <= 1'b1;
            end else begin
                rsp_out   <= alu_out;
                rsp_flags <= alu_flags;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: reset, ALU results, arbitration,
// backpressure, illegal opcodes and reset in the middle of an operation.

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_opcode, req1_opcode;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp_out;
    logic [2:0]  rsp_flags;
    logic        rsp_err, busy;

    int total = 0;
    int bad   = 0;
    int expg;

    always #5 clk = ~clk;

    alu_arbiter #(.BW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp_out     (rsp_out),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
        if (port == 0) begin
            req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
        end
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " req0_ready"}, req0_ready, 0);
        checkOutput({tag, " req1_ready"}, req1_ready, 0);
        checkOutput({tag, " rsp0_valid"}, rsp0_valid, 0);
        checkOutput({tag, " rsp1_valid"}, rsp1_valid, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " rsp_out"}, rsp_out, 0);
        checkOutput({tag, " rsp_flags"}, rsp_flags, 0);
        checkOutput({tag, " rsp_err"}, rsp_err, 0);
    endtask

    // One full transaction on a port, starting in an IDLE cycle, with the response taken at once.
    task automatic runOp(input string tag, input int port, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] eo,
                         input logic [2:0] ef, input logic ee);
        int n = 0;
        applyStimulus(port, op, a, b);
        while (!(port == 0 ? req0_ready : req1_ready) && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, " accepted"}, (n < 20), 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        checkOutput({tag, " exec busy"}, busy, 1);
        checkOutput({tag, " exec no rsp"}, {rsp1_valid, rsp0_valid}, 0);
        tick();
        checkOutput({tag, " rsp_valid"}, {rsp1_valid, rsp0_valid}, (port == 0) ? 2'b01 : 2'b10);
        checkOutput({tag, " rsp_out"}, rsp_out, eo);
        checkOutput({tag, " rsp_flags"}, rsp_flags, ef);
        checkOutput({tag, " rsp_err"}, rsp_err, ee);
        if (port == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        checkOutput({tag, " back idle"}, busy, 0);
        checkOutput({tag, " rsp held"}, rsp_out, eo);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        checkIdleOutputs("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] single ADD");
        runOp("add", 0, 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, 1'b0);

        $display("[TB] async reset mid-sim");
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rst");
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] fairness");
        applyStimulus(0, 4'd1, 16'h0005, 16'h0005);
        applyStimulus(1, 4'd1, 16'h0005, 16'h0005);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            expg = 0;
`else
            expg = i % 2;
`endif
            checkOutput($sformatf("fair%0d ready", i), {req1_ready, req0_ready},
                        (expg == 0) ? 2'b01 : 2'b10);
            tick();
            checkOutput($sformatf("fair%0d exec ready", i), {req1_ready, req0_ready}, 0);
            tick();
            checkOutput($sformatf("fair%0d rsp_valid", i), {rsp1_valid, rsp0_valid},
                        (expg == 0) ? 2'b01 : 2'b10);
            checkOutput($sformatf("fair%0d rsp_out", i), rsp_out, 16'h0000);
            checkOutput($sformatf("fair%0d rsp_flags", i), rsp_flags, 3'b001);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick();

        $display("[TB] backpressure");
        applyStimulus(1, 4'd4, 16'h00FF, 16'h0F0F);
        checkOutput("bp accept", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        applyStimulus(0, 4'd6, 16'hAAAA, 16'h0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp%0d rsp1_valid", i), rsp1_valid, 1);
            checkOutput($sformatf("bp%0d rsp_out", i), rsp_out, 16'h0FF0);
            checkOutput($sformatf("bp%0d req0_ready", i), req0_ready, 0);
            tick();
        end
        checkOutput("bp rsp_flags", rsp_flags, 3'b000);
        rsp1_ready = 1'b1;
        #1;
        checkOutput("bp hs rsp1_valid", rsp1_valid, 1);
        checkOutput("bp hs req0_ready", req0_ready, 0);
        tick();
        rsp1_ready = 1'b0;
        #1;
        checkOutput("bp next req0_ready", req0_ready, 1);
        checkOutput("bp next rsp1_valid", rsp1_valid, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        checkOutput("bp mova rsp0_valid", rsp0_valid, 1);
        checkOutput("bp mova rsp_out", rsp_out, 16'hAAAA);
        checkOutput("bp mova rsp_flags", rsp_flags, 3'b010);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        $display("[TB] opcode table");
        runOp("illegal", 0, 4'b1000, 16'h0001, 16'h0002, 16'h0000, 3'b000, 1'b1);
        runOp("movb", 0, 4'd7, 16'hFFFF, 16'h1234, 16'h1234, 3'b000, 1'b0);
        runOp("inc", 1, 4'd5, 16'h7FFF, 16'h0000, 16'h8000, 3'b110, 1'b0);
        runOp("and", 0, 4'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000, 1'b0);
        runOp("or", 1, 4'd3, 16'h8000, 16'h0001, 16'h8001, 3'b010, 1'b0);
        runOp("subneg", 0, 4'd1, 16'h0003, 16'h0005, 16'hFFFE, 3'b010, 1'b0);
        runOp("subovf", 1, 4'd1, 16'h8000, 16'h0001, 16'h7FFF, 3'b100, 1'b0);

        $display("[TB] reset mid-EXEC");
        applyStimulus(1, 4'd6, 16'h4321, 16'h0000);
        checkOutput("midrst accept", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst busy", busy, 0);
        checkOutput("midrst rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("midrst quiet%0d", i), {busy, rsp1_valid, rsp0_valid}, 0);
        end
        applyStimulus(0, 4'd6, 16'h5555, 16'h0000);
        applyStimulus(1, 4'd6, 16'h6666, 16'h0000);
        checkOutput("midrst prio", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0;
        tick();
        checkOutput("midrst rsp0_valid", rsp0_valid, 1);
        checkOutput("midrst rsp_out", rsp_out, 16'h5555);
        req1_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared combinational `alu` datapath. It accepts operations on two independent valid/ready request ports and grants one at a time. It captures the operands, runs them through an internal `alu` instance, registers the result and flags, and returns them on the granted requester's response port with backpressure. It sits between the register-file/control units and the single ALU, so the ALU is never driven by two masters in the same cycle.

## Interface
- `BW`, 16, datapath width; passed to the internal `alu` instance; must be ≥ 2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request pending on port 0 / 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_opcode` / `req1_opcode`  in  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 MOVA, 7 MOVB.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  BW  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for port 0 / 1.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the result.
- `rsp_out`  out  BW  result; shared by both ports, qualified by `rspN_valid`.
- `rsp_flags`  out  3  {overflow, negative, zero}; shared.
- `rsp_err`  out  1  illegal opcode (opcode[3] = 1).
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `reqN_valid` is high, pick the grant and drive `reqN_ready` = 1, combinationally, for that port only.
  - Capture the opcode and operands into internal registers, record the grant, and go to EXEC.
- **EXEC**
  - The internal `alu` is driven only from the captured registers.
  - At the end of the cycle, register `out` into `rsp_out` and `flags` into `rsp_flags`, unmodified, then go to RESP.
  - If captured opcode[3] = 1, the ALU is not used: `rsp_out` = 0, `rsp_flags` = 3'b000, `rsp_err` = 1. Otherwise `rsp_err` = 0.
- **RESP**
  - Hold `rspN_valid` = 1 for the granted port, with data stable, until `rspN_ready` = 1.
  - On that handshake cycle, go to IDLE. `rsp_out`, `rsp_flags` and `rsp_err` keep their values until the next EXEC.
- **Round-robin arbitration**
  - Register `last_grant`.
  - If both ports request in IDLE, grant the port that is not `last_grant`.
  - If only one port requests, grant it regardless of `last_grant`.
  - Update `last_grant` on every accept.
- **Request rules**
  - A requester must hold valid, opcode and operands stable until it sees ready.
  - A valid that drops before ready is not a transaction.
  - `reqN_ready` is never high outside IDLE.
- **Response rules**
  - `rspN_valid` of the non-granted port is always 0.
  - `rspN_ready` is ignored outside RESP.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - State IDLE, `last_grant` = 1 (port 0 has priority first).
  - All `req*_ready` and `rsp*_valid` = 0; `busy` = 0.
  - `rsp_out` = 0, `rsp_flags` = 3'b000, `rsp_err` = 0.
- Latency: request accepted in cycle T gives `rspN_valid` high in cycle T+2.
- Throughput: with `rspN_ready` tied high, the next request can be accepted in T+3, so one operation per 3 cycles maximum.
- Back-to-back: a request pending during RESP is accepted in the first IDLE cycle after the response handshake.
- Reset mid-operation (EXEC or RESP):
  - The in-flight operation is discarded and no response is issued.
  - After `rst_n` rises, the first grant follows reset priority (port 0).

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Port 0 always wins when both ports request; `last_grant` is not implemented.
  - Undefined (default): round-robin as above.
- All other behaviour is identical in both modes.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-simulation → all outputs 0, `busy` = 0, within the same cycle, with no clock edge needed.
- **Single ADD:** `req0` opcode 0, a = 0x7FFF, b = 0x0001, accepted in T → `rsp0_valid` at T+2, `rsp_out` = 0x8000, `rsp_flags` = 3'b110, `rsp_err` = 0, `rsp1_valid` = 0.
- **Fairness:** both ports request from reset, each a SUB 0x0005 − 0x0005, repeated four times.
  - Default build: grant order 0, 1, 0, 1, each response `rsp_out` = 0x0000, `rsp_flags` = 3'b001.
  - `ALU_ARB_FIXED_PRIO_EN` build: order 0, 0, 0, 0 while port 0 keeps requesting.
- **Backpressure:** `req1` XOR 0x00FF ^ 0x0F0F with `rsp1_ready` low for 5 cycles → `rsp1_valid` held and `rsp_out` = 0x0FF0 stable throughout; `req0_ready` stays 0 until the cycle after the handshake.
- **Illegal opcode:** `req0` opcode 4'b1000 → `rsp_err` = 1, `rsp_out` = 0, `rsp_flags` = 3'b000; the next legal MOVB b = 0x1234 → `rsp_err` = 0, `rsp_out` = 0x1234.
- **Reset mid-EXEC:** pulse `rst_n` low during EXEC → no `rsp*_valid` ever appears for that request; after release the FSM is in IDLE and a new request completes in 2 cycles.
